// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU): quotient to LO, remainder to HI.
// Latency: start accepted in cycle 0, done pulses in cycle WIDTH+1, idle again in cycle WIDTH+2.
// Backpressure: stall holds the execute stage from the accepting cycle until done; start is ignored unless IDLE.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, cancel     divide request (sampled in IDLE) and pipeline flush (wins over start)
//   is_signed, a, b   mode (1 = two's complement), dividend, divisor; latched on accept
//   stall, done       execute-stage hold (combinational), one-cycle completion pulse
//   quot, rem         quotient / remainder, held until the next completed divide
//   div_by_zero       set with the result when the latched divisor was zero
module iter_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    // Dividend magnitude; shifted left each step while quotient bits enter at the LSB.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;     // divisor magnitude
    logic [WIDTH-1:0] prem_q;    // partial remainder, always < dsr_q between steps
    logic [WIDTH-1:0] a_raw_q;   // unmodified dividend, returned as remainder on divide by zero
    logic             neg_q_q;
    logic             neg_r_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    // Operand conditioning. |MIN| = 2^(WIDTH-1) fits in WIDTH unsigned bits,
    // so plain two's-complement negation gives the correct magnitude.
    logic             sgn_d;
    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;

    assign sgn_d   = SIGNED_EN && is_signed;
    assign a_neg_d = sgn_d && a[WIDTH-1];
    assign b_neg_d = sgn_d && b[WIDTH-1];
    assign a_mag_d = a_neg_d ? (~a + 1'b1) : a;
    assign b_mag_d = b_neg_d ? (~b + 1'b1) : b;

    // One restoring step. The shifted remainder needs WIDTH+1 bits for the
    // compare; when its top bit is set it is necessarily >= the divisor, and
    // the true difference then fits in WIDTH bits.
    logic [WIDTH:0]   shifted_d;
    logic             take_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] prem_d;
    logic [WIDTH-1:0] qraw_d;
    logic [WIDTH-1:0] quot_fix_d;
    logic [WIDTH-1:0] rem_fix_d;
    logic             last_d;

    assign shifted_d  = {prem_q, dvd_q[WIDTH-1]};
    assign take_d     = (shifted_d >= {1'b0, dsr_q});
    assign diff_d     = shifted_d[WIDTH-1:0] - dsr_q;
    assign prem_d     = take_d ? diff_d : shifted_d[WIDTH-1:0];
    assign qraw_d     = {dvd_q[WIDTH-2:0], take_d};
    // MIN / -1: magnitude quotient 2^(WIDTH-1) with no negation reads back as MIN.
    assign quot_fix_d = neg_q_q ? (~qraw_d + 1'b1) : qraw_d;
    assign rem_fix_d  = neg_r_q ? (~prem_d + 1'b1) : prem_d;
    assign last_d     = (cnt_q == CW'(WIDTH - 1));

    assign stall       = ((state_q == IDLE) && start && !cancel) || (state_q == BUSY);
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            a_raw_q <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (cancel) begin
            // Flush: abandon the operation, results keep their last completed value.
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= a_mag_d;
                        dsr_q   <= b_mag_d;
                        prem_q  <= '0;
                        a_raw_q <= a;
                        neg_q_q <= a_neg_d ^ b_neg_d;
                        neg_r_q <= a_neg_d;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    prem_q <= prem_d;
                    dvd_q  <= qraw_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_d) begin
                        if (dsr_q == '0) begin
                            // Divide by zero bypasses sign correction entirely.
                            quot_q <= '1;
                            rem_q  <= a_raw_q;
                            dz_q   <= 1'b1;
                        end else begin
                            quot_q <= quot_fix_d;
                            rem_q  <= rem_fix_d;
                            dz_q   <= 1'b0;
                        end
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here so the same instruction is not re-issued.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         stall, done, div_by_zero;
    logic [W-1:0] quot, rem;

    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         stall8, done8, dz8;
    logic [7:0]   quot8, rem8;

    iter_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .is_signed(is_signed),
        .a(a), .b(b), .stall(stall), .done(done), .quot(quot), .rem(rem),
        .div_by_zero(div_by_zero)
    );

    iter_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .cancel(1'b0), .is_signed(is_signed),
        .a(a8), .b(b8), .stall(stall8), .done(done8), .quot(quot8), .rem(rem8),
        .div_by_zero(dz8)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    // Reference behaviour from the language's own arithmetic (truncating division,
    // remainder carries the dividend's sign), plus the two special cases.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        if (y == '0) begin
            e.q = '1; e.r = x; e.dz = 1'b1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.q = x; e.r = '0; e.dz = 1'b0;
        end else if (s) begin
            e.q = $signed(x) / $signed(y); e.r = $signed(x) % $signed(y); e.dz = 1'b0;
        end else begin
            e.q = x / y; e.r = x % y; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Presents a request in the cycle following the next rising edge (cycle 0).
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(posedge clk); #1;
        a = x; b = y; is_signed = s; start = 1'b1;
    endtask

    // Waits (bounded) for done; reports the done cycle relative to the first
    // sampled cycle and how many sampled cycles had stall high. Returns at the
    // falling edge of the done cycle, or with done_cyc = -1 on timeout.
    task automatic wait_done(input bit keep_start, output int done_cyc, output int stall_cnt);
        done_cyc  = -1;
        stall_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
            if (!keep_start) start = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({quot, rem, done, div_by_zero, stall} !== '0)
            $display("FAIL reset_outputs: quot=%h rem=%h done=%b dz=%b stall=%b, required all 0",
                     quot, rem, done, div_by_zero, stall);
        else n_pass++;
        n_checks++;
        if ({quot8, rem8, done8, dz8, stall8} !== '0)
            $display("FAIL reset_outputs8: quot=%h rem=%h done=%b dz=%b stall=%b, required all 0",
                     quot8, rem8, done8, dz8, stall8);
        else n_pass++;
        start = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL reset_stall_start: stall=%b, required 1", stall);
        else n_pass++;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int   dc, sc;
        exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        sb.push_back(exp_t'{q: 32'd14, r: 32'd2, dz: 1'b0});
        wait_done(1'b0, dc, sc);
        n_checks++;
        if (dc !== W + 1) $display("FAIL unsigned_done_cycle: got %0d, required %0d", dc, W + 1);
        else n_pass++;
        n_checks++;
        if (sc !== W + 1) $display("FAIL unsigned_stall_cycles: got %0d, required %0d", sc, W + 1);
        else n_pass++;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL unsigned_stall_in_done: stall=%b, required 0", stall);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({quot, rem, div_by_zero} !== {e.q, e.r, e.dz})
            $display("FAIL unsigned_result: quot=%0d rem=%0d dz=%b, required quot=%0d rem=%0d dz=%b",
                     quot, rem, div_by_zero, e.q, e.r, e.dz);
        else n_pass++;
        last_q = e.q; last_r = e.r;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL unsigned_done_pulse: done=%b one cycle later, required 0", done);
        else n_pass++;
    endtask

    task automatic test_signed;
        logic [W-1:0] ta[2] = '{32'hFFFF_FFF9, 32'h8000_0000};
        logic [W-1:0] tb[2] = '{32'd2,         32'hFFFF_FFFF};
        logic [W-1:0] tq[2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        logic [W-1:0] tr[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
        int   dc, sc;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], 1'b1);
            sb.push_back(exp_t'{q: tq[i], r: tr[i], dz: 1'b0});
            wait_done(1'b0, dc, sc);
            e = sb.pop_front();
            n_checks++;
            if (dc !== W + 1 || {quot, rem, div_by_zero} !== {e.q, e.r, e.dz})
                $display("FAIL signed_%0d: cycle=%0d quot=%h rem=%h dz=%b, required cycle=%0d quot=%h rem=%h dz=%b",
                         i, dc, quot, rem, div_by_zero, W + 1, e.q, e.r, e.dz);
            else n_pass++;
            last_q = e.q; last_r = e.r;
        end
    endtask

    task automatic test_div_zero;
        int   dc, sc;
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            issue(32'd5, 32'd0, s[0]);
            sb.push_back(exp_t'{q: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1});
            wait_done(1'b0, dc, sc);
            e = sb.pop_front();
            n_checks++;
            if (dc !== W + 1 || {quot, rem, div_by_zero} !== {e.q, e.r, e.dz})
                $display("FAIL div_zero_s%0d: cycle=%0d quot=%h rem=%h dz=%b, required cycle=%0d quot=%h rem=%h dz=%b",
                         s, dc, quot, rem, div_by_zero, W + 1, e.q, e.r, e.dz);
            else n_pass++;
            last_q = e.q; last_r = e.r;
        end
    endtask

    task automatic test_random;
        int           dc, sc;
        exp_t         e;
        logic [W-1:0] x, y;
        logic         s;
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = W'($urandom_range(1, 20));
                1:       y = -W'($urandom_range(1, 20));
                default: y = $urandom >> $urandom_range(0, 24);
            endcase
            s = 1'($urandom_range(0, 1));
            issue(x, y, s);
            sb.push_back(model(x, y, s));
            wait_done(1'b0, dc, sc);
            e = sb.pop_front();
            n_checks++;
            if (dc !== W + 1 || {quot, rem, div_by_zero} !== {e.q, e.r, e.dz})
                $display("FAIL random_%0d (%h / %h s=%b): cycle=%0d quot=%h rem=%h dz=%b, required cycle=%0d quot=%h rem=%h dz=%b",
                         i, x, y, s, dc, quot, rem, div_by_zero, W + 1, e.q, e.r, e.dz);
            else n_pass++;
            last_q = e.q; last_r = e.r;
        end
    endtask

    task automatic test_cancel;
        int bad_stall = 0;
        int extra = 0;
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (!stall) bad_stall++;
            @(posedge clk); #1;
            start  = 1'b0;
            cancel = (c == 9);
        end
        n_checks++;
        if (bad_stall !== 0) $display("FAIL cancel_stall_before: %0d low cycles, required 0", bad_stall);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) $display("FAIL cancel_stall_after: stall=%b in cycle 11, required 0", stall);
        else n_pass++;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done || stall) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL cancel_no_done: %0d cycles with done/stall, required 0", extra);
        else n_pass++;
        n_checks++;
        if (quot !== last_q || rem !== last_r)
            $display("FAIL cancel_hold: quot=%h rem=%h, required quot=%h rem=%h", quot, rem, last_q, last_r);
        else n_pass++;
    endtask

    task automatic test_cancel_with_start;
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; is_signed = 1'b0; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) $display("FAIL cancel_start_stall: stall=%b, required 0", stall);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) $display("FAIL cancel_start_not_busy: stall=%b next cycle, required 0", stall);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int extra = 0;
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({quot, rem, done, div_by_zero, stall} !== '0)
            $display("FAIL reset_mid: quot=%h rem=%h done=%b dz=%b stall=%b, required all 0",
                     quot, rem, done, div_by_zero, stall);
        else n_pass++;
        last_q = '0; last_r = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || stall) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL reset_mid_no_done: %0d cycles with done/stall, required 0", extra);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int   dc, sc;
        int   extra = 0;
        exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        sb.push_back(exp_t'{q: 32'd14, r: 32'd2, dz: 1'b0});
        wait_done(1'b1, dc, sc);
        e = sb.pop_front();
        n_checks++;
        if (dc !== W + 1 || {quot, rem} !== {e.q, e.r})
            $display("FAIL b2b_first: cycle=%0d quot=%0d rem=%0d, required cycle=%0d quot=%0d rem=%0d",
                     dc, quot, rem, W + 1, e.q, e.r);
        else n_pass++;
        // start stays high; the operands seen in cycle 34 are 9 / 4.
        a = 32'd9; b = 32'd4;
        sb.push_back(exp_t'{q: 32'd2, r: 32'd1, dz: 1'b0});
        wait_done(1'b0, dc, sc);
        e = sb.pop_front();
        n_checks++;
        if (dc + W + 2 !== 2 * W + 3 || {quot, rem, div_by_zero} !== {e.q, e.r, e.dz})
            $display("FAIL b2b_second: cycle=%0d quot=%0d rem=%0d dz=%b, required cycle=%0d quot=%0d rem=%0d dz=%b",
                     dc + W + 2, quot, rem, div_by_zero, 2 * W + 3, e.q, e.r, e.dz);
        else n_pass++;
        last_q = e.q; last_r = e.r;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL b2b_extra_done: %0d extra done cycles, required 0", extra);
        else n_pass++;
    endtask

    task automatic test_width8;
        int dc = -1;
        @(posedge clk); #1;
        a8 = 8'd200; b8 = 8'd3; is_signed = 1'b1; start8 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        n_checks++;
        if (dc !== 9 || quot8 !== 8'd66 || rem8 !== 8'd2 || dz8 !== 1'b0)
            $display("FAIL width8_unsigned: cycle=%0d quot=%0d rem=%0d dz=%b, required cycle=9 quot=66 rem=2 dz=0",
                     dc, quot8, rem8, dz8);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_random;
        test_cancel;
        test_cancel_with_start;
        test_reset_mid;
        test_back_to_back;
        test_width8;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised iterative radix-2 restoring divider for the execute stage of the MIPS pipeline. It serves DIV/DIVU: `quot` is written to LO and `rem` to HI. The operand width, signed-mode support and a pipeline-flush cancel are configurable. It drives the execute-stage divide stall and completes one quotient bit per cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits; legal values ≥ 4.
- `SIGNED_EN`, 1, when 0 `is_signed` is ignored and every operation is unsigned.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a divide using `a`, `b` and `is_signed`. Sampled only in IDLE.
- `cancel` in 1: flush. Aborts any operation in progress.
- `is_signed` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `a` in WIDTH: dividend.
- `b` in WIDTH: divisor.
- `stall` out 1: holds the execute stage while a divide is pending.
- `done` out 1: one-cycle pulse; `quot`/`rem` are valid from this cycle.
- `quot` out WIDTH: quotient (to LO).
- `rem` out WIDTH: remainder (to HI).
- `div_by_zero` out 1: registered with the result; 1 when `b` was 0.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - When `start`=1 and `cancel`=0: latch operands and mode, clear the bit counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle: shift the partial remainder left 1 and bring in the next dividend magnitude bit (MSB first). If the result is ≥ the divisor magnitude, subtract and set the quotient bit; otherwise restore.
  - The counter runs 0..WIDTH-1. At WIDTH-1, load the final results into `quot`/`rem`/`div_by_zero` and go to DONE.
- DONE: assert `done` for one cycle and go to IDLE. `start` is ignored in DONE, so the same instruction is never re-issued.
- Signed mode:
  - Operands are converted to magnitudes. A WIDTH+1-bit internal magnitude is not needed: `|MIN|` = 2^(WIDTH-1) is representable as unsigned.
  - Quotient is negated when sign(a) ≠ sign(b). Remainder takes the sign of `a`. Result satisfies a = q·b + r, with |r| < |b|.
  - MIN / −1 gives `quot` = MIN (wrap) and `rem` = 0. No trap is raised.
- Divide by zero (either mode):
  - The full WIDTH cycles still run.
  - Result is forced to `quot` = all ones and `rem` = `a` (raw operand), bypassing sign correction. `div_by_zero` = 1.
- `quot`, `rem` and `div_by_zero` hold their value until the next completed operation. They are not changed by a cancel.
- `stall` = (IDLE ∧ `start` ∧ ¬`cancel`) ∨ BUSY. This is combinational, so stall rises in the same cycle `start` is first presented.
- The caller must deassert `start`, or advance the instruction, in the cycle after `done`. A `start` held high in the following IDLE cycle begins a new divide.

## Timing
- Reset (asynchronous, any state):
  - State → IDLE, counter → 0.
  - `quot`, `rem` → 0; `done`, `div_by_zero` → 0.
  - `stall` = 0 unless `start` is high.
- Latency: `start` accepted in cycle 0 → BUSY in cycles 1..WIDTH → `done` = 1 in cycle WIDTH+1 → IDLE in cycle WIDTH+2.
- `stall` is high for cycles 0..WIDTH and low in the `done` cycle, so the pipeline advances at the end of cycle WIDTH+1.
- Minimum issue interval: WIDTH+2 cycles. A new `start` is accepted in cycle WIDTH+2.
- `cancel`:
  - Takes effect at the next edge from any state: → IDLE, no `done`, results unchanged.
  - `cancel` in the same cycle as `start` wins, so `stall` = 0 in that cycle.
  - `cancel` in the DONE cycle: `done` is still asserted (results already loaded), then IDLE.
- Operand inputs may change freely after cycle 0; only the latched copies are used.

## Test plan
- WIDTH=32, unsigned, a=100, b=7, start in cycle 0:
  - `stall` high in cycles 0..32.
  - `done` in cycle 33 with `quot`=14, `rem`=2, `div_by_zero`=0.
- Signed:
  - a=0xFFFFFFF9 (−7), b=2 → `quot`=0xFFFFFFFD (−3), `rem`=0xFFFFFFFF (−1).
  - a=0x80000000, b=0xFFFFFFFF → `quot`=0x80000000, `rem`=0.
- Divide by zero: a=5, b=0 (signed and unsigned) → `done` in cycle 33, `quot`=0xFFFFFFFF, `rem`=5, `div_by_zero`=1.
- Cancel and reset:
  - Start 100/7, pulse `cancel` in cycle 10 → `stall` = 0 from cycle 11, no `done` ever, `quot`/`rem` keep their previous values.
  - Repeat with `rst` asserted in cycle 10 → all outputs 0 immediately.
- Back-to-back: 100/7 then `start` held through the DONE cycle and into cycle 34 with 9/4 → second `done` in cycle 67 (34 + 33) with `quot`=2, `rem`=1. No extra `done`.
- WIDTH=8, SIGNED_EN=0, a=200, b=3, `is_signed`=1 → treated as unsigned: `done` in cycle 9, `quot`=66, `rem`=2.
